// File: rtl/k12a_stack_ctl_if.sv
// Request/response and strobe bundle between the microsequencer, the stack controller and the SP/memory side.
// The controller is the master; the shared address and data buses remain plain inout ports on the controller.
interface k12a_stack_ctl_if;
    logic       push_req;
    logic       pop_req;
    logic [7:0] push_data;
    logic [7:0] pop_data;
    logic       busy;
    logic       done;
    logic       fault;
    logic       sp_load_n;
    logic       sp_store;
    logic       mem_read_n;
    logic       mem_write_n;

    modport master (
        input  push_req, pop_req, push_data,
        output pop_data, busy, done, fault,
        output sp_load_n, sp_store, mem_read_n, mem_write_n
    );

    modport slave (
        output push_req, pop_req, push_data,
        input  pop_data, busy, done, fault,
        input  sp_load_n, sp_store, mem_read_n, mem_write_n
    );
endinterface

// File: rtl/k12a_stack_ctl.sv
// Stack push/pop sequencer: reads SP, adjusts it by one, and runs the byte access (limit checks under K12A_STACK_LIMIT_EN).
// Latency: 3 cycles from accept to done; back-to-back operations are 4 cycles apart.
// Backpressure: requests are sampled only in IDLE and are ignored, not queued, while busy.
module k12a_stack_ctl #(
    parameter logic [15:0] STACK_FLOOR = 16'hFF00,
    parameter logic [15:0] STACK_TOP   = 16'h0000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    k12a_stack_ctl_if.master        ctl,
    inout  wire  [15:0]             addr_bus,
    inout  wire  [7:0]              data_bus
);

    typedef enum logic [2:0] {
        IDLE,
        RDSP_PUSH,
        ADJ_PUSH,
        WR,
        RDSP_POP,
        RD,
        ADJ_POP
`ifdef K12A_STACK_LIMIT_EN
        , FAULT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tmp_q, tmp_d;
    logic [7:0]  pop_data_q, pop_data_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        addr_oe;
    logic [15:0] addr_out;
    logic        data_oe;
    logic        busy;
    logic        done;
    logic        fault;
    logic        sp_load_n;
    logic        sp_store;
    logic        mem_read_n;
    logic        mem_write_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tmp_q      <= 16'h0000;
            pop_data_q <= 8'h00;
            wdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            tmp_q      <= tmp_d;
            pop_data_q <= pop_data_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmp_d      = tmp_q;
        pop_data_d = pop_data_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE: begin
                if (ctl.push_req) begin
                    wdata_d = ctl.push_data;
                    state_d = RDSP_PUSH;
                end else if (ctl.pop_req) begin
                    state_d = RDSP_POP;
                end
            end
            RDSP_PUSH: begin
                tmp_d   = addr_bus;
                state_d = ADJ_PUSH;
`ifdef K12A_STACK_LIMIT_EN
                if (addr_bus == STACK_FLOOR) state_d = FAULT;
`endif
            end
            ADJ_PUSH: begin
                tmp_d   = tmp_q - 16'd1;
                state_d = WR;
            end
            WR:       state_d = IDLE;
            RDSP_POP: begin
                tmp_d   = addr_bus;
                state_d = RD;
`ifdef K12A_STACK_LIMIT_EN
                if (addr_bus == STACK_TOP) state_d = FAULT;
`endif
            end
            RD: begin
                pop_data_d = data_bus;
                state_d    = ADJ_POP;
            end
            ADJ_POP:  state_d = IDLE;
`ifdef K12A_STACK_LIMIT_EN
            FAULT:    state_d = IDLE;
`endif
            default:  state_d = IDLE;
        endcase
    end

    // Everything below is a pure decode of state_q, so no request input reaches an output.
    always_comb begin
        addr_oe     = 1'b0;
        addr_out    = tmp_q;
        data_oe     = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        sp_load_n   = 1'b1;
        sp_store    = 1'b0;
        mem_read_n  = 1'b1;
        mem_write_n = 1'b1;
        case (state_q)
            RDSP_PUSH, RDSP_POP: sp_load_n = 1'b0;
            ADJ_PUSH: begin
                addr_oe  = 1'b1;
                addr_out = tmp_q - 16'd1;
                sp_store = 1'b1;
            end
            WR: begin
                addr_oe     = 1'b1;
                data_oe     = 1'b1;
                mem_write_n = 1'b0;
                done        = 1'b1;
            end
            RD: begin
                addr_oe    = 1'b1;
                mem_read_n = 1'b0;
            end
            ADJ_POP: begin
                addr_oe  = 1'b1;
                addr_out = tmp_q + 16'd1;
                sp_store = 1'b1;
                done     = 1'b1;
            end
`ifdef K12A_STACK_LIMIT_EN
            FAULT: begin
                fault = 1'b1;
                done  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

`ifndef K12A_STACK_LIMIT_EN
    // The limit parameters only matter when the limit checks are built in.
    logic unused_limits;
    assign unused_limits = ^{STACK_FLOOR, STACK_TOP};
`endif

    assign addr_bus = addr_oe ? addr_out : 16'hzzzz;
    assign data_bus = data_oe ? wdata_q  : 8'hzz;

    assign ctl.pop_data    = pop_data_q;
    assign ctl.busy        = busy;
    assign ctl.done        = done;
    assign ctl.fault       = fault;
    assign ctl.sp_load_n   = sp_load_n;
    assign ctl.sp_store    = sp_store;
    assign ctl.mem_read_n  = mem_read_n;
    assign ctl.mem_write_n = mem_write_n;

endmodule

// File: tb/tb_k12a_stack_ctl.sv
// Directed bench for k12a_stack_ctl with a behavioural SP register and byte memory on the shared buses.
// Limit-feature steps are compiled in only when K12A_STACK_LIMIT_EN is defined.
module tb_k12a_stack_ctl;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    k12a_stack_ctl_if ifc();
    wire [15:0] addr_bus;
    wire [7:0]  data_bus;

    k12a_stack_ctl #(
        .STACK_FLOOR (16'hFF00),
        .STACK_TOP   (16'h0000)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ctl      (ifc),
        .addr_bus (addr_bus),
        .data_bus (data_bus)
    );

    logic [15:0] sp_reg = 16'h0000;
    logic [7:0]  mem [0:65535];
    logic        sp_set       = 1'b0;
    logic [15:0] sp_set_val   = 16'h0000;
    logic        mem_set      = 1'b0;
    logic [15:0] mem_set_addr = 16'h0000;
    logic [7:0]  mem_set_val  = 8'h00;
    logic        probe_en     = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int bad         = 0;
    logic [15:0] exp_sp;
    logic        is_push;

    // SP register drives the bus while loaded; memory drives data while read; probes show a released bus.
    assign addr_bus = (!ifc.sp_load_n) ? sp_reg : (probe_en ? 16'h5A5A : 16'hzzzz);
    assign data_bus = (!ifc.mem_read_n) ? mem[addr_bus] : (probe_en ? 8'hC3 : 8'hzz);

    always @(posedge clock) begin
        if (sp_set)             sp_reg <= sp_set_val;
        else if (ifc.sp_store)  sp_reg <= addr_bus;
        if (mem_set)              mem[mem_set_addr] <= mem_set_val;
        else if (!ifc.mem_write_n) mem[addr_bus] <= data_bus;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic preload_sp(input logic [15:0] v);
        sp_set_val = v;
        sp_set     = 1'b1;
        tick;
        sp_set     = 1'b0;
    endtask

    task automatic preload_mem(input logic [15:0] a, input logic [7:0] v);
        mem_set_addr = a;
        mem_set_val  = v;
        mem_set      = 1'b1;
        tick;
        mem_set      = 1'b0;
    endtask

    task automatic bus_mon;
        int s;
        s = 0;
        if (!ifc.sp_load_n)   s++;
        if (ifc.sp_store)     s++;
        if (!ifc.mem_read_n)  s++;
        if (!ifc.mem_write_n) s++;
        if (s > 1) bad++;
        if (!ifc.sp_load_n && (addr_bus !== sp_reg)) bad++;
    endtask

    initial begin
        ifc.push_req  = 1'b0;
        ifc.pop_req   = 1'b0;
        ifc.push_data = 8'h00;

        // Reset state
        #2;
        chk("rst_busy",        {31'd0, ifc.busy},        32'd0);
        chk("rst_done",        {31'd0, ifc.done},        32'd0);
        chk("rst_fault",       {31'd0, ifc.fault},       32'd0);
        chk("rst_sp_load_n",   {31'd0, ifc.sp_load_n},   32'd1);
        chk("rst_sp_store",    {31'd0, ifc.sp_store},    32'd0);
        chk("rst_mem_read_n",  {31'd0, ifc.mem_read_n},  32'd1);
        chk("rst_mem_write_n", {31'd0, ifc.mem_write_n}, 32'd1);
        chk("rst_pop_data",    {24'd0, ifc.pop_data},    32'h00);
        probe_en = 1'b1;
        #1;
        chk("rst_addr_released", {16'd0, addr_bus}, 32'h5A5A);
        chk("rst_data_released", {24'd0, data_bus}, 32'hC3);
        probe_en = 1'b0;
        #9;
        reset_n = 1'b1;

        // Push A5 at SP=0000: wraps to FFFF
        preload_sp(16'h0000);
        ifc.push_data = 8'hA5;
        ifc.push_req  = 1'b1;
        tick;
        ifc.push_req  = 1'b0;
        ifc.push_data = 8'h00;
        chk("push_rdsp_sp_load_n", {31'd0, ifc.sp_load_n}, 32'd0);
        chk("push_rdsp_busy",      {31'd0, ifc.busy},      32'd1);
        chk("push_rdsp_addr",      {16'd0, addr_bus},      32'h0000);
        tick;
        chk("push_adj_sp_store",   {31'd0, ifc.sp_store},  32'd1);
        chk("push_adj_addr",       {16'd0, addr_bus},      32'hFFFF);
        chk("push_adj_done",       {31'd0, ifc.done},      32'd0);
        tick;
        chk("push_wr_write_n",     {31'd0, ifc.mem_write_n}, 32'd0);
        chk("push_wr_addr",        {16'd0, addr_bus},        32'hFFFF);
        chk("push_wr_data",        {24'd0, data_bus},        32'hA5);
        chk("push_wr_done",        {31'd0, ifc.done},        32'd1);
        chk("push_wr_sp_store",    {31'd0, ifc.sp_store},    32'd0);
        tick;
        chk("push_idle_busy",      {31'd0, ifc.busy},        32'd0);
        chk("push_sp",             {16'd0, sp_reg},          32'hFFFF);
        chk("push_mem",            {24'd0, mem[16'hFFFF]},   32'hA5);

        // Pop at SP=FFFF with memory[FFFF]=3C: wraps to 0000
        preload_mem(16'hFFFF, 8'h3C);
        ifc.pop_req = 1'b1;
        tick;
        ifc.pop_req = 1'b0;
        chk("pop_rdsp_sp_load_n", {31'd0, ifc.sp_load_n},  32'd0);
        chk("pop_rdsp_addr",      {16'd0, addr_bus},       32'hFFFF);
        tick;
        chk("pop_rd_read_n",      {31'd0, ifc.mem_read_n}, 32'd0);
        chk("pop_rd_addr",        {16'd0, addr_bus},       32'hFFFF);
        tick;
        chk("pop_adj_sp_store",   {31'd0, ifc.sp_store},   32'd1);
        chk("pop_adj_addr",       {16'd0, addr_bus},       32'h0000);
        chk("pop_adj_done",       {31'd0, ifc.done},       32'd1);
        chk("pop_data",           {24'd0, ifc.pop_data},   32'h3C);
        tick;
        chk("pop_sp",             {16'd0, sp_reg},         32'h0000);
        chk("pop_idle_busy",      {31'd0, ifc.busy},       32'd0);

        // Both requests: push wins, held pop accepted 4 cycles later
        ifc.push_data = 8'h77;
        ifc.push_req  = 1'b1;
        ifc.pop_req   = 1'b1;
        tick;
        ifc.push_req  = 1'b0;
        chk("prio_rdsp_sp_load_n", {31'd0, ifc.sp_load_n},  32'd0);
        tick;
        chk("prio_adj_sp_store",   {31'd0, ifc.sp_store},   32'd1);
        chk("prio_adj_no_read",    {31'd0, ifc.mem_read_n}, 32'd1);
        chk("prio_adj_addr",       {16'd0, addr_bus},       32'hFFFF);
        tick;
        chk("prio_wr_done",        {31'd0, ifc.done},        32'd1);
        chk("prio_wr_write_n",     {31'd0, ifc.mem_write_n}, 32'd0);
        tick;
        chk("prio_idle_busy",      {31'd0, ifc.busy},        32'd0);
        tick;
        ifc.pop_req = 1'b0;
        chk("prio_pop_sp_load_n",  {31'd0, ifc.sp_load_n},  32'd0);
        chk("prio_pop_busy",       {31'd0, ifc.busy},       32'd1);
        tick;
        chk("prio_pop_read_n",     {31'd0, ifc.mem_read_n}, 32'd0);
        tick;
        chk("prio_pop_done",       {31'd0, ifc.done},       32'd1);
        chk("prio_pop_data",       {24'd0, ifc.pop_data},   32'h77);
        tick;
        chk("prio_sp",             {16'd0, sp_reg},         32'h0000);

        // Reset asserted during ADJ_PUSH, before its edge
        ifc.push_data = 8'h11;
        ifc.push_req  = 1'b1;
        tick;
        ifc.push_req  = 1'b0;
        tick;
        chk("rstmid_adj_sp_store", {31'd0, ifc.sp_store}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy",        {31'd0, ifc.busy},        32'd0);
        chk("rstmid_sp_store",    {31'd0, ifc.sp_store},    32'd0);
        chk("rstmid_sp_load_n",   {31'd0, ifc.sp_load_n},   32'd1);
        chk("rstmid_mem_write_n", {31'd0, ifc.mem_write_n}, 32'd1);
        chk("rstmid_mem_read_n",  {31'd0, ifc.mem_read_n},  32'd1);
        chk("rstmid_done",        {31'd0, ifc.done},        32'd0);
        chk("rstmid_pop_data",    {24'd0, ifc.pop_data},    32'h00);
        probe_en = 1'b1;
        #1;
        chk("rstmid_addr_released", {16'd0, addr_bus}, 32'h5A5A);
        chk("rstmid_data_released", {24'd0, data_bus}, 32'hC3);
        probe_en = 1'b0;
        tick;
        chk("rstmid_sp_unchanged", {16'd0, sp_reg}, 32'h0000);
        #2;
        reset_n = 1'b1;

`ifdef K12A_STACK_LIMIT_EN
        // Push at the floor faults without writing
        preload_sp(16'hFF00);
        ifc.push_data = 8'hEE;
        ifc.push_req  = 1'b1;
        tick;
        ifc.push_req  = 1'b0;
        tick;
        chk("lim_push_fault",    {31'd0, ifc.fault},       32'd1);
        chk("lim_push_done",     {31'd0, ifc.done},        32'd1);
        chk("lim_push_no_write", {31'd0, ifc.mem_write_n}, 32'd1);
        chk("lim_push_no_store", {31'd0, ifc.sp_store},    32'd0);
        tick;
        chk("lim_push_sp",       {16'd0, sp_reg},          32'hFF00);
        chk("lim_push_idle",     {31'd0, ifc.busy},        32'd0);
        chk("lim_push_fault_end",{31'd0, ifc.fault},       32'd0);

        // Legal pop to reach an empty stack, then a pop that faults
        preload_sp(16'hFFFF);
        preload_mem(16'hFFFF, 8'h9D);
        ifc.pop_req = 1'b1;
        tick;
        ifc.pop_req = 1'b0;
        tick;
        tick;
        tick;
        chk("lim_pop_ok_data", {24'd0, ifc.pop_data}, 32'h9D);
        chk("lim_pop_ok_sp",   {16'd0, sp_reg},       32'h0000);
        ifc.pop_req = 1'b1;
        tick;
        ifc.pop_req = 1'b0;
        tick;
        chk("lim_pop_fault",    {31'd0, ifc.fault},      32'd1);
        chk("lim_pop_done",     {31'd0, ifc.done},       32'd1);
        chk("lim_pop_no_read",  {31'd0, ifc.mem_read_n}, 32'd1);
        chk("lim_pop_no_store", {31'd0, ifc.sp_store},   32'd0);
        tick;
        chk("lim_pop_data_kept", {24'd0, ifc.pop_data},  32'h9D);
        chk("lim_pop_sp",        {16'd0, sp_reg},        32'h0000);
`endif

        // Random push/pop stream with per-cycle bus-rule monitoring
        preload_sp(16'h0000);
        exp_sp = 16'h0000;
        bad    = 0;
        for (int i = 0; i < 1000; i++) begin
            is_push       = 1'($urandom_range(0, 1));
            ifc.push_req  = is_push;
            ifc.pop_req   = !is_push;
            ifc.push_data = 8'($urandom_range(0, 255));
            tick;
            ifc.push_req  = 1'b0;
            ifc.pop_req   = 1'b0;
            bus_mon;
            tick;
            bus_mon;
            tick;
            bus_mon;
            tick;
            bus_mon;
            if (ifc.busy) bad++;
`ifdef K12A_STACK_LIMIT_EN
            if (!((is_push && exp_sp == 16'hFF00) || (!is_push && exp_sp == 16'h0000)))
                exp_sp = is_push ? exp_sp - 16'd1 : exp_sp + 16'd1;
`else
            exp_sp = is_push ? exp_sp - 16'd1 : exp_sp + 16'd1;
`endif
        end
        chk("rand_bus_rules", bad,              32'd0);
        chk("rand_sp",        {16'd0, sp_reg},  {16'd0, exp_sp});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/k12a_stack_ctl.md
Name: k12a_stack_ctl

Overview:
- Stack push/pop sequencer; the master side of the SP register's address-bus interface.
- Drives sp_load_n to read SP onto addr_bus and computes SP-1 (push) or SP+1 (pop).
- Drives the new value back onto addr_bus with sp_store, and runs the single-byte memory access.
- Sits in the control path beside the SP register and the memory interface; requested by the microsequencer.

Parameters:
- STACK_FLOOR, 16'hFF00: lowest legal SP after a push. Used only with K12A_STACK_LIMIT_EN.
- STACK_TOP, 16'h0000: SP value meaning "stack empty". Used only with K12A_STACK_LIMIT_EN.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- push_req  input  1  request push of push_data; sampled in IDLE only.
- pop_req  input  1  request pop into pop_data; sampled in IDLE only.
- push_data  input  8  byte to push; sampled on the accept edge.
- pop_data  output  8  last popped byte; holds until the next pop completes.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse in the final state of an operation.
- fault  output  1  one-cycle pulse on limit violation (optional feature only, else tied 0).
- sp_load_n  output  1  active-low; SP register drives addr_bus.
- sp_store  output  1  SP register captures addr_bus at next edge.
- addr_bus  inout  16  shared address bus; this block drives it or releases it to 16'hzzzz.
- data_bus  inout  8  memory data bus; driven only during a push write.
- mem_read_n  output  1  active-low memory read strobe.
- mem_write_n  output  1  active-low memory write strobe.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; tmp=16'h0000; pop_data=8'h00; wdata=8'h00.
  - busy=0, done=0, fault=0.
  - sp_load_n=1, sp_store=0, mem_read_n=1, mem_write_n=1.
  - addr_bus and data_bus released.
  - A reset mid-operation abandons it; SP is left unchanged unless the ADJ edge had already occurred.
- Strobes and bus enables are decoded from the state register (Moore); no combinational path from request inputs to outputs.
- IDLE:
  - push_req=1 -> latch push_data into wdata, go to RDSP_PUSH.
  - else pop_req=1 -> RDSP_POP.
  - Push has priority when both are high. Requests while busy are ignored, not queued.
- Push (full-descending, pre-decrement), 3 cycles after accept:
  - RDSP_PUSH: sp_load_n=0, this block releases addr_bus, tmp<=addr_bus at edge -> ADJ_PUSH.
  - ADJ_PUSH: drive addr_bus=tmp-1 (mod 2^16, 16'h0000 -> 16'hFFFF), sp_store=1, tmp<=tmp-1 -> WR.
  - WR: drive addr_bus=tmp, data_bus=wdata, mem_write_n=0, done=1 -> IDLE.
- Pop (post-increment), 3 cycles after accept:
  - RDSP_POP: sp_load_n=0, tmp<=addr_bus -> RD.
  - RD: drive addr_bus=tmp, mem_read_n=0, pop_data<=data_bus at edge -> ADJ_POP.
  - ADJ_POP: drive addr_bus=tmp+1 (mod 2^16, 16'hFFFF -> 16'h0000), sp_store=1, done=1 -> IDLE.
- Bus rules:
  - Never drive addr_bus in a cycle where sp_load_n=0.
  - At most one of sp_load_n=0, sp_store, mem_read_n=0, mem_write_n=0 is active per cycle.
  - data_bus is driven only in WR.
- Back-to-back: a request held high through the done cycle is accepted on the edge after the block returns to IDLE, so operations are 4 cycles apart.

Optional Feature:
- Macro: K12A_STACK_LIMIT_EN.
- Push: when the value read in RDSP_PUSH equals STACK_FLOOR, go to FAULT instead of ADJ_PUSH.
- Pop: when the value read in RDSP_POP equals STACK_TOP, go to FAULT instead of RD.
- FAULT state: lasts one cycle, fault=1, done=1, no sp_store, no memory strobe, pop_data unchanged; then IDLE.
- Without the macro: no comparators and no FAULT state; fault is tied 0; push and pop wrap freely.

Test Plan:
- SP=16'h0000, push_req with push_data=8'hA5 -> sp_store cycle drives 16'hFFFF; WR drives addr 16'hFFFF, data 8'hA5, mem_write_n=0; done on cycle 3 after accept; SP=16'hFFFF.
- SP=16'hFFFF, memory[FFFF]=8'h3C, pop_req -> mem_read_n=0 with addr 16'hFFFF; pop_data=8'h3C; sp_store cycle drives 16'h0000; SP=16'h0000.
- push_req and pop_req high together in IDLE -> push executes; pop is taken on the following IDLE cycle if still held; pushes/pops are 4 cycles apart.
- Assert reset_n=0 during ADJ_PUSH (before the edge) -> all strobes inactive immediately, both buses high-Z, busy=0, SP unchanged.
- Bus check over 1000 random push/pop requests -> addr_bus never driven in a cycle with sp_load_n=0; never more than one active strobe per cycle.
- K12A_STACK_LIMIT_EN with STACK_FLOOR=16'hFF00 and SP=16'hFF00, push -> fault and done pulse in the same cycle; no write; SP stays 16'hFF00. Pop at SP=16'h0000 -> fault; pop_data unchanged.
